// File: rtl/xosera_bus_master.sv
// Host-side initiator for the Xosera 8-bit register bus: turns one 16-bit register request into
// one or two timed byte cycles, and synchronises the Xosera interrupt into the host clock domain.
module xosera_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_bytesel,
    input  logic [3:0]  req_reg,
    input  logic [15:0] req_wdata,

    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,

    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i,

    input  logic        bus_intr_i,
    output logic        intr_o,
    output logic        intr_pulse_o
);

    localparam int unsigned MaxSt     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES
                                                                       : STROBE_CYCLES;
    localparam int unsigned MaxCycles = (MaxSt > HOLD_CYCLES) ? MaxSt : HOLD_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    // The phase counter holds "cycles remaining minus one" so a phase ends when it reads zero.
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            second_q, second_d;
    logic            cs_n_q;

    logic            wr_q;
    logic            byte_q;
    logic            bsel_q;
    logic [3:0]      reg_q;
    logic [15:0]     wdata_q;
    logic [15:0]     rdata_q;

    logic            accept;
    logic            capture;
    logic            active;
    logic            cur_bsel;
    logic            low_byte;

    logic            sync1_q, sync2_q, intr_prev_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        second_d = second_q;
        accept   = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    state_d  = StSetup;
                    cnt_d    = SetupLoad;
                    second_d = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    if (!byte_q && !second_q) begin
                        state_d  = StSetup;
                        cnt_d    = SetupLoad;
                        second_d = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            second_q <= 1'b0;
            cs_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            second_q <= second_d;
            // Registered from the next state so chip select cannot glitch through decode logic.
            cs_n_q   <= (state_d != StStrobe);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            bsel_q  <= 1'b0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            byte_q  <= req_byte;
            bsel_q  <= req_bytesel;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (capture && !wr_q) begin
            if (low_byte) begin
                rdata_q[7:0] <= bus_data_i;
            end else begin
                rdata_q[15:8] <= bus_data_i;
            end
        end
    end

    // Word accesses run high byte first, then low byte; byte accesses use the requested lane.
    assign low_byte = byte_q || second_q;
    assign cur_bsel = byte_q ? bsel_q : second_q;
    assign active   = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);

    assign req_ready     = (state_q == StIdle);
    assign rsp_valid     = (state_q == StResp);
    assign rsp_rdata     = rdata_q;

    assign bus_cs_n_o    = cs_n_q;
    assign bus_rd_nwr_o  = !(wr_q && active);
    assign bus_reg_num_o = reg_q;
    assign bus_bytesel_o = cur_bsel;
    assign bus_data_o    = low_byte ? wdata_q[7:0] : wdata_q[15:8];
    assign bus_data_oe_o = wr_q && active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            intr_prev_q <= 1'b0;
        end else begin
            sync1_q     <= bus_intr_i;
            sync2_q     <= sync1_q;
            intr_prev_q <= sync2_q;
        end
    end

    assign intr_o       = sync2_q;
    assign intr_pulse_o = sync2_q && !intr_prev_q;

endmodule

// File: doc/xosera_bus_master.md
Name: xosera_bus_master

Overview:
- Host-side initiator for the Xosera 8-bit register bus. Drives the cs_n / rd_nwr / reg_num / bytesel / data pins that the video core samples.
- Converts a single 16-bit register read or write request (valid/ready) into one or two timed byte cycles, and returns read data on a response pulse.
- Also synchronises the Xosera interrupt line into the host clock domain.
- Sits between a CPU/test sequencer and the xosera_main bus pins.

Parameters:
- SETUP_CYCLES, 1, cycles address/rd_nwr/bytesel/data are stable with cs_n high before the strobe (>=1).
- STROBE_CYCLES, 3, cycles cs_n is held low (>=1).
- HOLD_CYCLES, 1, cycles cs_n is high with address/data still held after the strobe (>=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_byte  in  1  1 = single-byte access, 0 = 16-bit word access
- req_bytesel  in  1  byte lane for a single-byte access (0 = high byte, 1 = low byte)
- req_reg  in  4  register number
- req_wdata  in  16  write data; only [7:0] is used for byte writes
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  16  read data, valid while rsp_valid is high
- bus_cs_n_o  out  1  chip select, active low
- bus_rd_nwr_o  out  1  1 = read, 0 = write
- bus_reg_num_o  out  4  register number
- bus_bytesel_o  out  1  0 = high (even) byte, 1 = low (odd) byte
- bus_data_o  out  8  write data to Xosera
- bus_data_oe_o  out  1  host drives the data bus
- bus_data_i  in  8  read data from Xosera
- bus_intr_i  in  1  Xosera interrupt, asynchronous
- intr_o  out  1  synchronised interrupt level
- intr_pulse_o  out  1  one-cycle pulse on each synchronised rising edge

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, bus_cs_n_o=1, bus_rd_nwr_o=1, bus_reg_num_o=0, bus_bytesel_o=0, bus_data_o=0, bus_data_oe_o=0, req_ready=1, rsp_valid=0, rsp_rdata=0, intr_o=0, intr_pulse_o=0, synchroniser flops=0.
- Reset asserted mid-cycle: cs_n returns high in the same instant, any partial read data is discarded, no rsp_valid is issued.
- States: IDLE -> SETUP -> STROBE -> HOLD -> (second byte ? SETUP : RESP) -> IDLE.
- IDLE: req_ready=1. On accept, latch all req_* fields, then enter SETUP on the next cycle.
- req_ready is 0 in every state other than IDLE; at most one request is outstanding.
- SETUP (SETUP_CYCLES): cs_n=1. reg_num, rd_nwr and bytesel are driven. For writes, data_o carries the current byte and data_oe=1; for reads, data_oe=0.
- STROBE (STROBE_CYCLES): cs_n=0, all other outputs unchanged. For reads, bus_data_i is registered on the final STROBE cycle.
- HOLD (HOLD_CYCLES): cs_n=1, address, data and data_oe held. Leaving the last HOLD cycle: for a word access after the first byte, go to SETUP for the second byte; otherwise go to RESP.
- Word order: the first byte uses bytesel=0 and byte wdata[15:8], read into rdata[15:8]. The second byte uses bytesel=1 and byte wdata[7:0], read into rdata[7:0].
- Byte access: one byte cycle only, bytesel=req_bytesel, byte wdata[7:0]. Read data goes into rsp_rdata[7:0]; rsp_rdata[15:8]=0.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata is stable during that cycle. For writes, rsp_rdata=0. Then IDLE, where req_ready=1 in the same cycle rsp_valid deasserts.
- Between bytes, cs_n is high for at least HOLD_CYCLES+SETUP_CYCLES cycles. cs_n never glitches low outside STROBE.
- Latency for an accept at cycle 0: a word access completes with rsp_valid at cycle 2*(S+T+H)+1; a byte access at cycle (S+T+H)+1, where S=SETUP_CYCLES, T=STROBE_CYCLES, H=HOLD_CYCLES. With defaults: word at cycle 11, byte at cycle 6.
- req_* inputs changing after accept have no effect.
- A single phase counter is sized for max(S,T,H) and reloaded on each state entry.
- Interrupt path: 2-flop synchroniser, intr_o = second flop. intr_pulse_o = intr_o && !previous intr_o. Latency from a clean bus_intr_i edge to intr_o is 2 clocks. This path runs independently of the bus state machine.

Test Plan:
- Word write, reg=4'h3, wdata=16'hA55A, defaults. Required: two strobes, each with cs_n low for exactly 3 cycles; byte 1 has bytesel=0, data=8'hA5, rd_nwr=0; byte 2 has bytesel=1, data=8'h5A; rsp_valid pulses at cycle 11; req_ready=0 from cycle 1 through 11.
- Word read, reg=4'hB, with the Xosera model returning 8'h12 then 8'h34. Required: data_oe=0 throughout; rsp_rdata=16'h1234 with rsp_valid at cycle 11.
- Byte read, req_bytesel=1, model returns 8'hC7. Required: a single strobe with bytesel=1; rsp_rdata=16'h00C7 at cycle 6.
- Back-to-back requests with req_valid held high. Required: the second request is accepted in the cycle after rsp_valid; cs_n stays high for >=2 cycles between the last byte of request 1 and the first byte of request 2; SETUP/STROBE/HOLD = 2/1/2 gives a word latency of 11.
- reset_n pulsed low during the first STROBE of a word write. Required: cs_n=1 and data_oe=0 immediately; no rsp_valid; after release, a new request completes normally.
- bus_intr_i rising at cycle 0, held for 5 cycles. Required: intr_o=1 at cycle 2; intr_pulse_o high only at cycle 2; intr_o returns to 0 two cycles after the input falls.
